// File: rtl/lab62_soc_p1_input_pio.sv
// ---------------------------------------------------------------------------
// lab62_soc_p1_input_pio
//
// Avalon-MM input PIO for the player 1 buttons/status bus. The external bus
// is synchronised into the clk domain, optionally debounced, and watched for
// edges. Selected edges stick in EDGE_CAP until software clears them, and any
// captured bit whose IRQ_MASK bit is set raises a level interrupt. Slave
// timing is zero-wait with read latency 0, the same as the output PIO slaves.
//
// Register map (bits above WIDTH read 0 and are ignored on write):
//   0 DATA      RO   filtered input value
//   1 IRQ_MASK  RW   per-bit interrupt enable
//   2 EDGE_CAP  R/W1C captured edges
//   3 EDGE_MODE RW   bits[1:0]: 00 rising, 01 falling, 10 both, 11 disabled
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs (WIDTH bits)
//   readdata    read data, combinational from address and registers
//   irq         level interrupt, active high
//
// Optional feature: define P1_INPUT_DEBOUNCE_EN to add a per-bit debounce
// filter that requires DEBOUNCE_CYCLES stable cycles before a bit changes.
// Without the macro the filtered value is the synchroniser output and
// DEBOUNCE_CYCLES has no effect.
// ---------------------------------------------------------------------------
module lab62_soc_p1_input_pio #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  typedef enum logic [1:0] {
    MODE_RISE    = 2'b00,
    MODE_FALL    = 2'b01,
    MODE_BOTH    = 2'b10,
    MODE_DISABLE = 2'b11
  } edge_mode_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  edge_mode_e       edge_mode_q, edge_mode_d;
  logic [1:0]       settle_q, settle_d;

  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] edge_rise;
  logic [WIDTH-1:0] edge_fall;
  logic [WIDTH-1:0] edge_sel;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry register content; the XOR
  // keeps the remaining bits formally consumed.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect && !write_n;

  // Two-flop synchroniser on the raw pins.
  assign sync1_d = in_port;
  assign sync2_d = sync1_q;

`ifdef P1_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt_q [WIDTH];
  logic [CNT_W-1:0] db_cnt_d [WIDTH];
  logic [WIDTH-1:0] filtered_q, filtered_d;

  // A bit only follows the synchroniser after it has disagreed with the
  // filtered value for DEBOUNCE_CYCLES consecutive cycles; any agreeing
  // cycle restarts the count, so short glitches are discarded.
  always_comb begin
    filtered_d = filtered_q;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filtered_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          filtered_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      filtered_q <= filtered_d;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign filtered = filtered_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign filtered = sync2_q;
`endif

  // Edge detection against the previous filtered value, narrowed to the
  // edges the current mode asks for.
  assign prev_d    = filtered;
  assign edge_rise = filtered & ~prev_q;
  assign edge_fall = ~filtered & prev_q;

  always_comb begin
    edge_sel = '0;
    case (edge_mode_q)
      MODE_RISE:    edge_sel = edge_rise;
      MODE_FALL:    edge_sel = edge_fall;
      MODE_BOTH:    edge_sel = edge_rise | edge_fall;
      MODE_DISABLE: edge_sel = '0;
      default:      edge_sel = '0;
    endcase
  end

  // Settle counter: capture stays off for the first three cycles after reset
  // so the synchroniser filling up with held-high inputs is not seen as an
  // edge.
  assign settle_d = (settle_q == 2'd3) ? 2'd3 : settle_q + 2'd1;

  // Register writes. The W1C clear is applied before new edges are ORed in,
  // so a simultaneous clear and set of the same bit leaves it set.
  always_comb begin
    irq_mask_d  = irq_mask_q;
    edge_mode_d = edge_mode_q;
    edge_cap_d  = edge_cap_q;
    if (wr_en) begin
      case (address)
        ADDR_MASK: irq_mask_d  = writedata[WIDTH-1:0];
        ADDR_CAP:  edge_cap_d  = edge_cap_q & ~writedata[WIDTH-1:0];
        ADDR_MODE: edge_mode_d = edge_mode_e'(writedata[1:0]);
        default:   ;
      endcase
    end
    if (settle_q == 2'd3) begin
      edge_cap_d = edge_cap_d | edge_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      edge_mode_q <= MODE_RISE;
      settle_q    <= 2'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      edge_mode_q <= edge_mode_d;
      settle_q    <= settle_d;
    end
  end

  // Read mux, zero-extended; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = filtered;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_CAP:  readdata[WIDTH-1:0] = edge_cap_q;
      ADDR_MODE: readdata[1:0]       = edge_mode_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_lab62_soc_p1_input_pio.sv
// ---------------------------------------------------------------------------
// tb_lab62_soc_p1_input_pio
//
// Directed bench for the player 1 input PIO. A behavioural model tracks what
// every register must hold from the register-map rules, and a compare process
// checks readdata and irq against it on every falling clock edge. Directed
// steps add literal expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_lab62_soc_p1_input_pio;

  localparam int WIDTH = 8;
`ifdef P1_INPUT_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  // Edges from a pin change until DATA shows it.
  localparam int LAT = 2 + DEB;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = 8'hFF;
  logic [31:0]      readdata;
  logic             irq;

  int checks = 0;
  int failures = 0;

  lab62_soc_p1_input_pio #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // 20-unit clock so several back-to-back register reads fit between the
  // rising edge and the falling-edge compare.
  always #10 clk = ~clk;

  // Model state: pin history, the accepted value, previous accepted value,
  // the three software registers and the cycles since reset.
  logic [7:0] m_hist0 = '0;
  logic [7:0] m_hist1 = '0;
  logic [7:0] m_filt = '0;
  logic [7:0] m_prev = '0;
  logic [7:0] m_cap = '0;
  logic [7:0] m_mask = '0;
  logic [1:0] m_mode = '0;
  int         m_cycles = 0;
  int         m_run [8];
  logic [7:0] m_sel;
  logic [7:0] m_seen;

  // The model advances once per rising edge: edges are judged on the value
  // accepted before the edge, software writes land, then the pin history
  // shifts and the accepted value moves on.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hist0 = '0; m_hist1 = '0; m_filt = '0; m_prev = '0;
      m_cap = '0; m_mask = '0; m_mode = '0; m_cycles = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else begin
      case (m_mode)
        2'd0:    m_sel = m_filt & ~m_prev;
        2'd1:    m_sel = ~m_filt & m_prev;
        2'd2:    m_sel = m_filt ^ m_prev;
        default: m_sel = '0;
      endcase
      if (m_cycles < 3) m_sel = '0;
      if (chipselect && !write_n) begin
        case (address)
          2'd1: m_mask = writedata[7:0];
          2'd2: m_cap  = m_cap & ~writedata[7:0];
          2'd3: m_mode = writedata[1:0];
          default: ;
        endcase
      end
      m_cap  = m_cap | m_sel;
      m_prev = m_filt;
      m_seen = m_hist1;
`ifdef P1_INPUT_DEBOUNCE_EN
      for (int i = 0; i < 8; i++) begin
        if (m_seen[i] != m_filt[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_filt[i] = m_seen[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`else
      m_filt = m_hist0;
`endif
      m_hist1 = m_hist0;
      m_hist0 = in_port;
      if (m_cycles < 3) m_cycles++;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_filt};
      2'd1:    return {24'b0, m_mask};
      2'd2:    return {24'b0, m_cap};
      default: return {30'b0, m_mode};
    endcase
  endfunction

  // Continuous compare on every falling edge, away from the rising edge
  // where the DUT and model update.
  always @(negedge clk) begin
    checks++;
    if (readdata !== model_read(address)) begin
      failures++;
      $display("[TB] FAIL model_readdata addr=%0d actual=%h required=%h t=%0t",
               address, readdata, model_read(address), $time);
    end
    checks++;
    if (irq !== (|(m_cap & m_mask))) begin
      failures++;
      $display("[TB] FAIL model_irq actual=%b required=%b t=%0t",
               irq, |(m_cap & m_mask), $time);
    end
  end

  // Literal comparison used by the directed steps.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Point the read mux at a register and compare after it settles.
  task automatic checkReg(input logic [1:0] a, input logic [31:0] expected,
                          input string name);
    address = a;
    #1;
    checkOutput(name, readdata, expected);
  endtask

  // Drive the external pins.
  task automatic applyStimulus(input logic [7:0] pins);
    in_port = pins;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One-cycle write strobe starting now; returns just after the edge that
  // takes it.
  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Directed sequence.
  initial begin
    $display("[TB] start, debounce cycles=%0d", DEB);

    // Pins held high through reset.
    repeat (3) tick();
    checkReg(2'd0, 32'h0, "reset_data");
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkReg(2'd1, 32'h0, "reset_mask");
    checkReg(2'd3, 32'h0, "reset_mode");
    reset_n = 1'b1;
    repeat (10) tick();
    checkReg(2'd0, 32'h0000_00FF, "arm_data");
    checkReg(2'd2, (DEB == 0) ? 32'h0 : 32'h0000_00FF, "arm_cap");
    checkOutput("arm_irq", {31'b0, irq}, 32'h0);
    busWrite(2'd2, 32'hFF);

    // Rising capture, latency and interrupt.
    applyStimulus(8'h00);
    repeat (LAT + 2) tick();
    checkReg(2'd2, 32'h0, "falls_ignored_mode00");
    busWrite(2'd1, 32'h01);
    applyStimulus(8'h01);
    repeat (LAT - 1) tick();
    checkReg(2'd0, 32'h00, "data_before_latency");
    tick();
    checkReg(2'd0, 32'h01, "data_at_latency");
    checkReg(2'd2, 32'h00, "cap_before_edge");
    checkOutput("irq_before_edge", {31'b0, irq}, 32'h0);
    tick();
    checkReg(2'd2, 32'h01, "cap_rise");
    checkOutput("irq_rise", {31'b0, irq}, 32'h1);
    busWrite(2'd2, 32'h01);
    checkReg(2'd2, 32'h00, "cap_w1c");
    checkOutput("irq_after_w1c", {31'b0, irq}, 32'h0);

    // Falling-only mode.
    busWrite(2'd3, 32'h1);
    applyStimulus(8'h05);
    repeat (LAT + 2) tick();
    checkReg(2'd2, 32'h00, "mode01_rise_ignored");
    applyStimulus(8'h01);
    repeat (LAT + 1) tick();
    checkReg(2'd2, 32'h04, "mode01_fall");
    checkOutput("mode01_irq_masked", {31'b0, irq}, 32'h0);

    // Both-edges mode.
    busWrite(2'd2, 32'h04);
    busWrite(2'd3, 32'h2);
    applyStimulus(8'h05);
    repeat (LAT + 1) tick();
    checkReg(2'd2, 32'h04, "mode10_rise");
    busWrite(2'd2, 32'h04);
    checkReg(2'd2, 32'h00, "mode10_cleared");
    applyStimulus(8'h01);
    repeat (LAT + 1) tick();
    checkReg(2'd2, 32'h04, "mode10_fall");

    // Capture disabled.
    busWrite(2'd2, 32'h04);
    busWrite(2'd3, 32'h3);
    applyStimulus(8'h05);
    repeat (LAT + 2) tick();
    applyStimulus(8'h01);
    repeat (LAT + 2) tick();
    checkReg(2'd2, 32'h00, "mode11_none");
    checkReg(2'd3, 32'h03, "mode11_readback");

    // W1C colliding with a new edge on the same bit, then on other bits.
    busWrite(2'd3, 32'h0);
    applyStimulus(8'h03);
    repeat (LAT) tick();
    busWrite(2'd2, 32'h02);
    checkReg(2'd2, 32'h02, "w1c_collision_set_wins");
    busWrite(2'd2, 32'h01);
    checkReg(2'd2, 32'h02, "w1c_other_bit_intact");
    applyStimulus(8'h13);
    repeat (LAT) tick();
    busWrite(2'd2, 32'h02);
    checkReg(2'd2, 32'h10, "clear_and_set_same_cycle");

    // Masking, read-only DATA and ignored upper bits.
    busWrite(2'd2, 32'hFF);
    busWrite(2'd1, 32'h00);
    applyStimulus(8'h93);
    repeat (LAT + 1) tick();
    checkReg(2'd2, 32'h80, "mask_cap");
    checkOutput("mask_irq_off", {31'b0, irq}, 32'h0);
    busWrite(2'd1, 32'h80);
    checkOutput("mask_irq_next_cycle", {31'b0, irq}, 32'h1);
    busWrite(2'd0, 32'hFFFF_FFFF);
    checkReg(2'd0, 32'h93, "data_write_ignored");
    busWrite(2'd3, 32'hFFFF_FFFC);
    checkReg(2'd3, 32'h0, "mode_upper_bits_ignored");
    busWrite(2'd1, 32'hFFFF_FF00);
    checkReg(2'd1, 32'h0, "mask_upper_bits_ignored");
    checkOutput("mask_cleared_irq", {31'b0, irq}, 32'h0);

    // Reset in the middle of operation.
    busWrite(2'd1, 32'h80);
    checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_irq", {31'b0, irq}, 32'h0);
    checkReg(2'd2, 32'h0, "midreset_cap");
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    checkReg(2'd2, (DEB == 0) ? 32'h0 : 32'h93, "rearm_cap");
    checkReg(2'd1, 32'h0, "rearm_mask");

`ifdef P1_INPUT_DEBOUNCE_EN
    // Glitch shorter than the debounce window, then a held change.
    busWrite(2'd2, 32'hFF);
    applyStimulus(8'h92);
    repeat (12) tick();
    busWrite(2'd2, 32'hFF);
    applyStimulus(8'h93);
    repeat (3) tick();
    applyStimulus(8'h92);
    repeat (12) tick();
    checkReg(2'd0, 32'h92, "glitch_data");
    checkReg(2'd2, 32'h00, "glitch_cap");
    applyStimulus(8'h93);
    repeat (LAT - 1) tick();
    checkReg(2'd0, 32'h92, "debounce_data_before");
    tick();
    checkReg(2'd0, 32'h93, "debounce_data_at");
    checkReg(2'd2, 32'h00, "debounce_cap_before");
    tick();
    checkReg(2'd2, 32'h01, "debounce_cap");
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
